// File: rtl/abr_params_pkg.sv
// Shared arithmetic parameters for the ML-DSA datapath.
//   MLDSA_Q    : prime modulus of the coefficient ring
//   MLDSA_Q_X2 : 2*MLDSA_Q, upper bound of the single-subtract reduction window
package abr_params_pkg;
  localparam int MLDSA_Q    = 8380417;
  localparam int MLDSA_Q_X2 = 2 * MLDSA_Q;
endpackage

// File: rtl/ntt_defines_pkg.sv
// NTT datapath types shared by the masked and unmasked halves of the unit.
//   masked_share_t : two arithmetic shares, value = share0 + share1 mod 2^NTT_SHARE_W
//   ntt_stage_t    : view of one pipeline register slice {valid, last, data}
package ntt_defines_pkg;
  localparam int NTT_SHARE_W = 46;

  typedef logic [1:0][NTT_SHARE_W-1:0] masked_share_t;

  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic [2*NTT_SHARE_W-1:0] data;
  } ntt_stage_t;
endpackage

// File: rtl/ntt_pipe_stage.sv
// One valid/ready register slice with bubble collapsing.
// Ports:
//   clk, reset_n (async, active-low), zeroize (sync clear, highest priority)
//   up_valid/up_ready/up_data/up_last       : upstream side
//   down_valid/down_ready/down_data/down_last : downstream side (registered)
//
// Handshake: a beat moves across an interface on a clock edge where valid and
// ready are both high. The slice is ready whenever it is empty or its current
// content leaves this cycle, so an empty slot never blocks a follower. Valid
// never depends on ready; ready here is combinational from down_ready.
module ntt_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              zeroize,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_last,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [DATA_W-1:0] down_data,
  output logic              down_last
);

  logic load;

  assign up_ready = !down_valid || down_ready;
  assign load     = up_valid && up_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      down_valid <= 1'b0;
      down_last  <= 1'b0;
      down_data  <= '0;
    end else if (zeroize) begin
      down_valid <= 1'b0;
      down_last  <= 1'b0;
      down_data  <= '0;
    end else if (load) begin
      down_valid <= 1'b1;
      down_last  <= up_last;
      down_data  <= up_data;
    end else if (down_ready) begin
      // Content left and nothing replaced it: become a bubble. Data is kept
      // so the output bus does not toggle needlessly.
      down_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ntt_masked_share_unmask.sv
// Unmasks a two-share arithmetic coefficient from the masked BFU and delivers
// a reduced coefficient in [0, MLDSA_Q) toward the unmasked memory write path.
// Ports:
//   clk, reset_n (async, active-low), zeroize (sync clear of all state)
//   in_valid/in_ready, in_shares[1:0][WIDTH-1:0], in_last, rnd : input beat
//   out_valid/out_ready, out_coeff[COEFF_W-1:0], out_last      : output beat
//   range_err : sticky, a combined value reached 2*MLDSA_Q or more
//
// Three register stages, each an ntt_pipe_stage:
//   1 refresh : r0 = share0 + rnd, r1 = share1 - rnd   (mod 2^WIDTH)
//   2 combine : x  = r0 + r1                            (mod 2^WIDTH)
//   3 reduce  : x, x - Q, or truncated x - Q when out of range
// The shares are re-randomised in a register before they are ever summed, so
// no cycle has both raw shares feeding a single adder.
module ntt_masked_share_unmask
  import abr_params_pkg::*;
  import ntt_defines_pkg::*;
#(
  parameter int WIDTH   = 46,
  parameter int COEFF_W = 23
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  zeroize,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0][WIDTH-1:0] in_shares,
  input  logic                  in_last,
  input  logic [WIDTH-1:0]      rnd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COEFF_W-1:0]    out_coeff,
  output logic                  out_last,
  output logic                  range_err
);

  localparam logic [WIDTH-1:0]   Q_W   = WIDTH'(MLDSA_Q);
  localparam logic [WIDTH-1:0]   Q2_W  = WIDTH'(MLDSA_Q_X2);
  localparam logic [COEFF_W-1:0] Q_C   = COEFF_W'(MLDSA_Q);

  // Stage 1: refresh
  logic [2*WIDTH-1:0] s1_in;
  logic [2*WIDTH-1:0] s1_data;
  logic               s1_valid;
  logic               s1_last;
  logic               s1_ready;

  // Stage 2: combine
  logic [WIDTH-1:0]   s2_in;
  logic [WIDTH-1:0]   s2_data;
  logic               s2_valid;
  logic               s2_last;
  logic               s2_ready;

  // Stage 3: reduce
  logic [COEFF_W-1:0] s3_in;
  logic               s3_over;
  logic               s3_ready;
  logic               s3_load;

  assign s1_in = {in_shares[1] - rnd, in_shares[0] + rnd};

  ntt_pipe_stage #(.DATA_W(2*WIDTH)) u_stage_refresh (
    .clk        (clk),
    .reset_n    (reset_n),
    .zeroize    (zeroize),
    .up_valid   (in_valid),
    .up_ready   (in_ready),
    .up_data    (s1_in),
    .up_last    (in_last),
    .down_valid (s1_valid),
    .down_ready (s1_ready),
    .down_data  (s1_data),
    .down_last  (s1_last)
  );

  assign s2_in = s1_data[WIDTH-1:0] + s1_data[2*WIDTH-1:WIDTH];

  ntt_pipe_stage #(.DATA_W(WIDTH)) u_stage_combine (
    .clk        (clk),
    .reset_n    (reset_n),
    .zeroize    (zeroize),
    .up_valid   (s1_valid),
    .up_ready   (s1_ready),
    .up_data    (s2_in),
    .up_last    (s1_last),
    .down_valid (s2_valid),
    .down_ready (s2_ready),
    .down_data  (s2_data),
    .down_last  (s2_last)
  );

  // Both the in-window and out-of-range cases subtract Q once; only the low
  // COEFF_W bits survive, so the subtraction is done at that width directly.
  always_comb begin
    s3_in   = s2_data[COEFF_W-1:0];
    s3_over = 1'b0;
    if (s2_data >= Q_W) begin
      s3_in = s2_data[COEFF_W-1:0] - Q_C;
    end
    if (s2_data >= Q2_W) begin
      s3_over = 1'b1;
    end
  end

  ntt_pipe_stage #(.DATA_W(COEFF_W)) u_stage_reduce (
    .clk        (clk),
    .reset_n    (reset_n),
    .zeroize    (zeroize),
    .up_valid   (s2_valid),
    .up_ready   (s2_ready),
    .up_data    (s3_in),
    .up_last    (s2_last),
    .down_valid (out_valid),
    .down_ready (out_ready),
    .down_data  (out_coeff),
    .down_last  (out_last)
  );

  assign s3_load = s2_valid && s3_ready;
  assign s3_ready = s2_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      range_err <= 1'b0;
    end else if (zeroize) begin
      range_err <= 1'b0;
    end else if (s3_load && s3_over) begin
      range_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ntt_masked_share_unmask.sv
// Bench for ntt_masked_share_unmask: directed steps plus randomized streams,
// checked against a plain-arithmetic model of the unmask/reduce rules.
module tb_ntt_masked_share_unmask;

  localparam int    W  = 46;
  localparam int    CW = 23;
  localparam longint Q = 64'd8380417;

  logic                 clk;
  logic                 reset_n;
  logic                 zeroize;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0][W-1:0]    in_shares;
  logic                 in_last;
  logic [W-1:0]         rnd;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_coeff;
  logic                 out_last;
  logic                 range_err;

  ntt_masked_share_unmask #(.WIDTH(W), .COEFF_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .zeroize   (zeroize),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_shares (in_shares),
    .in_last   (in_last),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff),
    .out_last  (out_last),
    .range_err (range_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int out_count = 0;

  typedef struct {
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    bit           last;
  } item_t;

  item_t pend[$];
  // {err, last, coeff}
  logic [CW+1:0] exp_q[$];
  bit            exp_sticky = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: recombine with plain integer arithmetic, then reduce by the
  // three-way rule on the combined value.
  function automatic logic [CW+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit last);
    longint x;
    longint c;
    bit     err;
    x   = (longint'(a) + longint'(b)) % (longint'(1) << W);
    err = 1'b0;
    if (x < Q)           c = x;
    else if (x < 2 * Q)  c = x - Q;
    else begin
      c   = (x - Q) % (longint'(1) << CW);
      err = 1'b1;
    end
    return {err, last, c[CW-1:0]};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  bit            prev_stall = 1'b0;
  logic [CW-1:0] held_coeff;
  logic          held_last;
  logic [CW+1:0] e;

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall && out_valid) begin
        check("hold_coeff", 64'(out_coeff), 64'(held_coeff));
        check("hold_last", 64'(out_last), 64'(held_last));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_shares[0], in_shares[1], in_last));
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          exp_sticky = exp_sticky | e[CW+1];
          check("out_coeff", 64'(out_coeff), 64'(e[CW-1:0]));
          check("out_last", 64'(out_last), 64'(e[CW]));
          check("range_err", 64'(range_err), 64'(exp_sticky));
        end
      end
      prev_stall = out_valid && !out_ready;
      held_coeff = out_coeff;
      held_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic add_item(input logic [W-1:0] a, input logic [W-1:0] b, input bit l);
    item_t it;
    it.s0 = a;
    it.s1 = b;
    it.last = l;
    pend.push_back(it);
  endtask

  // Split coefficient c into two random shares.
  task automatic add_coeff(input longint c, input bit l);
    logic [W-1:0] s0;
    s0 = W'({$urandom(), $urandom()});
    add_item(s0, W'(c) - s0, l);
  endtask

  // One clock: present the next pending item (if any), set out_ready,
  // observe the handshake mid-cycle, and return 1 ns after the edge.
  task automatic step(input bit ordy, output bit acc);
    in_valid = (pend.size() != 0);
    if (in_valid) begin
      in_shares[0] = pend[0].s0;
      in_shares[1] = pend[0].s1;
      in_last      = pend[0].last;
    end else begin
      in_shares = '0;
      in_last   = 1'b0;
    end
    rnd       = W'({$urandom(), $urandom()});
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) void'(pend.pop_front());
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready held high, mode 1: out_ready random.
  task automatic run_stream(input int mode, input int budget);
    int cyc;
    bit acc;
    cyc = 0;
    while ((pend.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      step((mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)), acc);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("drain", 64'(pend.size() + exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit acc;
    int acc_count;
    int oc;

    reset_n   = 1'b0;
    zeroize   = 1'b0;
    in_valid  = 1'b0;
    in_shares = '0;
    in_last   = 1'b0;
    rnd       = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_coeff", 64'(out_coeff), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_range_err", 64'(range_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accept, then out_valid three clocks later.
    add_item(W'(64'h3FFF_FFFF_FFF9), W'(107), 1'b1);
    step(1'b1, acc);
    check("lat_accept", 64'(acc), 64'd1);
    check("lat_v_c1", 64'(out_valid), 64'd0);
    step(1'b1, acc);
    check("lat_v_c2", 64'(out_valid), 64'd0);
    step(1'b1, acc);
    check("lat_v_c3", 64'(out_valid), 64'd1);
    check("lat_coeff", 64'(out_coeff), 64'd100);
    check("lat_last", 64'(out_last), 64'd1);
    check("lat_range_err", 64'(range_err), 64'd0);
    step(1'b1, acc);
    run_stream(0, 20);

    // Reduction boundaries.
    add_item(W'(Q), W'(3), 1'b0);
    add_item(W'(Q - 1), W'(0), 1'b0);
    add_coeff(Q, 1'b0);
    add_coeff(2 * Q - 1, 1'b1);
    run_stream(0, 50);
    check("no_err_yet", 64'(range_err), 64'd0);

    // Out-of-range combine sets a sticky flag.
    add_item(W'(Q), W'(Q), 1'b0);
    add_item(W'(5), W'(6), 1'b0);
    add_item(W'(Q + 2), W'(0), 1'b1);
    run_stream(0, 50);
    check("range_sticky", 64'(range_err), 64'd1);

    // Zeroize with two coefficients in flight.
    add_coeff(11, 1'b0);
    add_coeff(22, 1'b1);
    step(1'b0, acc);
    step(1'b0, acc);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    zeroize   = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    exp_q.delete();
    exp_sticky = 1'b0;
    check("zero_out_valid", 64'(out_valid), 64'd0);
    check("zero_in_ready", 64'(in_ready), 64'd1);
    check("zero_range_err", 64'(range_err), 64'd0);
    check("zero_out_coeff", 64'(out_coeff), 64'd0);
    oc = out_count;
    repeat (6) step(1'b1, acc);
    check("zero_dropped", 64'(out_count - oc), 64'd0);

    // Back-pressure: six inputs, output stalled for five cycles.
    for (int i = 0; i < 6; i++) add_coeff(longint'($urandom_range(0, 8380416)), i == 5);
    acc_count = 0;
    repeat (5) begin
      step(1'b0, acc);
      acc_count += int'(acc);
    end
    check("bp_accepts", 64'(acc_count), 64'd3);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    oc = out_count;
    run_stream(0, 100);
    check("bp_count", 64'(out_count - oc), 64'd6);

    // 256-coefficient stream, random consumer, occasional out-of-range values.
    oc = out_count;
    for (int i = 0; i < 256; i++) begin
      add_coeff(longint'($urandom_range(0, 2 * 8380417 + 40)), i == 255);
    end
    run_stream(1, 3000);
    check("stream_count", 64'(out_count - oc), 64'd256);

    // Async reset with two in flight, one of them out of range.
    add_coeff(2 * Q + 5, 1'b0);
    add_coeff(7, 1'b0);
    step(1'b0, acc);
    step(1'b0, acc);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_sticky = 1'b0;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_range_err", 64'(range_err), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    oc = out_count;
    repeat (6) step(1'b1, acc);
    check("arst_dropped", 64'(out_count - oc), 64'd0);
    check("arst_err_after", 64'(range_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_masked_share_unmask.md
Name: ntt_masked_share_unmask

Overview:
- Receiving end of the masked NTT datapath: accepts a two-share arithmetic coefficient (value = share0 + share1 mod 2^WIDTH), as produced by the masked butterfly add/sub and mult units.
- Refreshes the shares, recombines them, reduces the result into [0, MLDSA_Q) and delivers one unmasked coefficient per accepted input.
- Sits between the masked BFU output and the unmasked memory write path.
- 3-stage valid/ready pipeline with full back-pressure and per-stage bubble collapsing.

Parameters:
- WIDTH, 46, share width (arithmetic modulus 2^WIDTH).
- COEFF_W, 23, output coefficient width; must satisfy 2^COEFF_W > MLDSA_Q.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear of all state, has priority over every other input
- in_valid  in  1  input share pair valid
- in_ready  out  1  unit can accept an input this cycle
- in_shares  in  [1:0][WIDTH]  arithmetic shares
- in_last  in  1  marks the final coefficient of a polynomial
- rnd  in  WIDTH  fresh randomness for refresh, sampled on accept
- out_valid  out  1  output coefficient valid
- out_ready  in  1  consumer accepts output
- out_coeff  out  COEFF_W  unmasked coefficient in [0, MLDSA_Q)
- out_last  out  1  in_last delayed with its coefficient
- range_err  out  1  sticky: a combined value was >= 2*MLDSA_Q

Behaviour:
Reset and clear:
- Asynchronous reset: out_valid=0, out_coeff=0, out_last=0, range_err=0, all stage valids and data 0, in_ready=1.
- zeroize: same values on the next edge, regardless of the handshake.
- Reset or zeroize mid-operation drops all in-flight coefficients; no output is produced for them.

Handshake and pipeline advance:
- Input is accepted when in_valid && in_ready. Output is transferred when out_valid && out_ready.
- Stage k (k=1..3) loads when it is empty, or when its content moves to stage k+1 (or out) this cycle.
- in_ready = !v1 || stage1 advances. This is combinational from out_ready through the stage valids.
- out_valid = v3. out_coeff and out_last are stable while out_valid && !out_ready.

Stage 1 (refresh register):
- r0 = share0 + rnd, r1 = share1 - rnd, both mod 2^WIDTH.
- Shares are never combined in the same cycle they arrive.

Stage 2 (combine register):
- x = r0 + r1 mod 2^WIDTH.

Stage 3 (reduce register):
- If x < MLDSA_Q: out_coeff = x.
- Else if x < 2*MLDSA_Q: out_coeff = x - MLDSA_Q.
- Else: out_coeff = (x - MLDSA_Q) truncated to COEFF_W, and range_err is set.
- range_err is set as stage 3 loads and is cleared only by reset or zeroize.

Latency and throughput:
- 3 clks from accept to out_valid with no stalls. 1 coefficient/clk sustained.
- Maximum occupancy 3. Order is always preserved.

Simultaneous events:
- Accept and output on the same cycle while full: all stages shift, no bubble, occupancy unchanged.
- in_valid high while in_ready low: the input is ignored, rnd is not consumed.

in_last:
- Travels with its data through all stages. No other effect.

Decomposition:
- MLDSA_Q and the 2*MLDSA_Q constant come from abr_params_pkg.
- ntt_defines_pkg gets a typedef for the masked share pair ([1:0][WIDTH-1:0]) and a stage struct {valid, last, data}.
- One natural sub-module, ntt_pipe_stage: a single valid/ready register slice with bubble collapsing, instantiated three times with a different datapath function between each pair.

Test Plan:
- in_shares={2^46-7, 107}, rnd=random, out_ready=1 -> out_coeff=100 exactly 3 clks after accept; out_last follows in_last; range_err=0.
- in_shares={MLDSA_Q, 3} -> out_coeff=3; in_shares={MLDSA_Q-1, 0} -> out_coeff=8380416.
- Combined value 2*MLDSA_Q (shares {MLDSA_Q, MLDSA_Q}) -> range_err=1 and stays high through later good inputs until zeroize clears it.
- Back-pressure: stream 6 inputs with out_ready=0 for 5 cycles -> in_ready drops after 3 accepts; out_coeff held stable; after release all 6 outputs appear in order with none lost or duplicated.
- Full-rate stream of 256 coefficients with random rnd and out_ready toggling randomly -> outputs match the reference model (share0+share1 mod 2^46, mod Q); out_last only on the 256th output.
- Assert reset_n, then separately zeroize, with 2 coefficients in flight -> next cycle out_valid=0, in_ready=1, range_err=0; the dropped coefficients never emerge.
